// File: rtl/gps_receiver2_if.sv
// CSR and Wishbone slave bus bundle for the GPS sample capture block.
// Pure wiring with no latency of its own.
// No backpressure: CSR is fire-and-forget, and Wishbone stalls through ack.
interface gps_receiver2_if;
    logic [14:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;

    modport slave (
        input  csr_a, csr_we, csr_di, wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i,
               wb_we_i, wb_sel_i,
        output csr_do, wb_dat_o, wb_ack_o
    );

    modport master (
        output csr_a, csr_we, csr_di, wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i,
               wb_we_i, wb_sel_i,
        input  csr_do, wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/gps_receiver2.sv
// GPS front-end serial capture: shifts bits into 32-bit words stored in a 256-word RAM, with CSR control and Wishbone readout.
// Latency: bit event is about 3 sys_clk after the front-end clock edge; CSR read takes 1 cycle; Wishbone ack comes 1 cycle after the strobe.
// Backpressure: none on capture (the RAM write pointer wraps and sets a sticky flag); Wishbone accesses stall only through ack.
module gps_receiver2 #(
    parameter logic [4:0] csr_addr = 5'h0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    gps_receiver2_if.slave   bus,
    input  logic             gps_rec_clk,
    input  logic             gps_rec_data,
    input  logic             gps_rec_sync
);

    logic [1:0]  clk_sy, dat_sy, syn_sy;
    logic        clk_d, syn_d;
    logic        bit_evt, sync_evt;

    logic        enable;
    logic        wrap;
    logic [4:0]  bit_cnt;
    logic [7:0]  wptr;
    logic [31:0] shift_reg;
    logic [31:0] synccnt;
    logic [31:0] scratch;
    logic [31:0] new_word;

    logic [31:0] ram [0:255];

    logic        csr_sel, csr_wr, ctrl_wr, clear;
    logic        word_done, wb_req;

    // Bits that are decoded away on purpose: the byte selects and the untouched address/data bits.
    logic        unused_bits;
    assign unused_bits = ^{bus.wb_sel_i, bus.wb_adr_i[31:13], bus.wb_adr_i[11:10],
                           bus.wb_adr_i[1:0], bus.csr_a[9:2], bus.csr_di[31:2]};

    assign bit_evt   = clk_sy[1] & ~clk_d;
    assign sync_evt  = syn_sy[1] & ~syn_d;
    assign new_word  = {shift_reg[30:0], dat_sy[1]};

    assign csr_sel   = (bus.csr_a[14:10] == csr_addr);
    assign csr_wr    = csr_sel & bus.csr_we;
    assign ctrl_wr   = csr_wr & (bus.csr_a[1:0] == 2'd0);
    assign clear     = ctrl_wr & bus.csr_di[1];
    // CLEAR wins over a coincident bit event, so the word that would complete is also dropped.
    assign word_done = enable & bit_evt & (bit_cnt == 5'd31) & ~clear;

    assign wb_req    = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;

    // Bring the asynchronous front-end lines into sys_clk, and keep one extra stage for edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            clk_sy <= '0;
            dat_sy <= '0;
            syn_sy <= '0;
            clk_d  <= 1'b0;
            syn_d  <= 1'b0;
        end else begin
            clk_sy <= {clk_sy[0], gps_rec_clk};
            dat_sy <= {dat_sy[0], gps_rec_data};
            syn_sy <= {syn_sy[0], gps_rec_sync};
            clk_d  <= clk_sy[1];
            syn_d  <= syn_sy[1];
        end
    end

    // Capture state: shift register, bit counter, write pointer, wrap flag and sync counter.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            enable    <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            wptr      <= '0;
            wrap      <= 1'b0;
            synccnt   <= '0;
        end else begin
            if (ctrl_wr)
                enable <= bus.csr_di[0];
            if (clear) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                wptr      <= '0;
                wrap      <= 1'b0;
                synccnt   <= '0;
            end else begin
                if (sync_evt)
                    synccnt <= synccnt + 32'd1;
                if (enable && bit_evt) begin
                    shift_reg <= new_word;
                    bit_cnt   <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        wptr <= wptr + 8'd1;
                        if (wptr == 8'hFF)
                            wrap <= 1'b1;
                    end
                end
            end
        end
    end

    // Sample RAM capture port. Its contents are deliberately never reset.
    always_ff @(posedge sys_clk) begin
        if (word_done)
            ram[wptr] <= new_word;
    end

    // Wishbone slave: a one-cycle ack per request, a registered read, and the scratch written on the acking edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= '0;
            scratch      <= '0;
        end else begin
            bus.wb_ack_o <= wb_req;
            if (wb_req) begin
                if (bus.wb_adr_i[12]) begin
                    bus.wb_dat_o <= scratch;
                    if (bus.wb_we_i)
                        scratch <= bus.wb_dat_i;
                end else begin
                    bus.wb_dat_o <= ram[bus.wb_adr_i[9:2]];
                end
            end
        end
    end

    // CSR readback, registered. It reads zero whenever this bank is not addressed.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus.csr_do <= '0;
        end else if (!csr_sel) begin
            bus.csr_do <= '0;
        end else begin
            case (bus.csr_a[1:0])
                2'd0:    bus.csr_do <= {31'd0, enable};
                2'd1:    bus.csr_do <= {24'd0, wptr};
                2'd2:    bus.csr_do <= {19'd0, bit_cnt, 7'd0, wrap};
                default: bus.csr_do <= synccnt;
            endcase
        end
    end

endmodule

// File: tb/tb_gps_receiver2.sv
module tb_gps_receiver2;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic gps_rec_clk = 1'b0;
    logic gps_rec_data = 1'b0;
    logic gps_rec_sync = 1'b0;

    int checks = 0;
    int failures = 0;

    gps_receiver2_if bus_if();

    gps_receiver2 #(.csr_addr(5'h0)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .bus          (bus_if.slave),
        .gps_rec_clk  (gps_rec_clk),
        .gps_rec_data (gps_rec_data),
        .gps_rec_sync (gps_rec_sync)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          phase;
        bit          is_wb;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int phase, input bit is_wb, input logic [31:0] addr,
                           input logic [31:0] exp, input string name);
        vec_t v;
        v.phase = phase;
        v.is_wb = is_wb;
        v.addr  = addr;
        v.exp   = exp;
        v.name  = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_read(input logic [14:0] a, input logic [31:0] exp, input string name);
        @(negedge sys_clk);
        bus_if.csr_a  = a;
        bus_if.csr_we = 1'b0;
        @(posedge sys_clk);
        #1;
        check(name, bus_if.csr_do, exp);
    endtask

    task automatic csr_write(input logic [14:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        bus_if.csr_a  = a;
        bus_if.csr_di = d;
        bus_if.csr_we = 1'b1;
        @(negedge sys_clk);
        bus_if.csr_we = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    // Holds the strobe for two edges: ack must be high after the first and low after the second.
    task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [31:0] exp, input string name);
        @(negedge sys_clk);
        bus_if.wb_adr_i = adr;
        bus_if.wb_dat_i = wdat;
        bus_if.wb_we_i  = we;
        bus_if.wb_cyc_i = 1'b1;
        bus_if.wb_stb_i = 1'b1;
        @(posedge sys_clk);
        #1;
        check({name, "_ack"}, {31'd0, bus_if.wb_ack_o}, 32'd1);
        if (!we)
            check(name, bus_if.wb_dat_o, exp);
        @(posedge sys_clk);
        #1;
        check({name, "_ack_pulse"}, {31'd0, bus_if.wb_ack_o}, 32'd0);
        @(negedge sys_clk);
        bus_if.wb_cyc_i = 1'b0;
        bus_if.wb_stb_i = 1'b0;
        bus_if.wb_we_i  = 1'b0;
    endtask

    task automatic send_bit(input logic d, input logic s);
        @(negedge sys_clk);
        gps_rec_data = d;
        gps_rec_sync = s;
        gps_rec_clk  = 1'b1;
        repeat (2) @(negedge sys_clk);
        gps_rec_clk  = 1'b0;
        gps_rec_sync = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic run_phase(input int p);
        repeat (4) @(negedge sys_clk);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                if (vecs[i].is_wb)
                    wb_access(1'b0, vecs[i].addr, 32'd0, vecs[i].exp, vecs[i].name);
                else
                    csr_read(vecs[i].addr[14:0], vecs[i].exp, vecs[i].name);
            end
        end
    endtask

    initial begin
        // Phase 0: reset values
        add_vec(0, 1'b0, 32'h0000, 32'h0000_0001, "rst_ctrl");
        add_vec(0, 1'b0, 32'h0001, 32'h0000_0000, "rst_wptr");
        add_vec(0, 1'b0, 32'h0002, 32'h0000_0000, "rst_status");
        add_vec(0, 1'b0, 32'h0003, 32'h0000_0000, "rst_synccnt");
        // Phase 1: 32 ones
        add_vec(1, 1'b1, 32'h0000, 32'hFFFF_FFFF, "ones_word0");
        add_vec(1, 1'b0, 32'h0001, 32'h0000_0001, "ones_wptr");
        add_vec(1, 1'b0, 32'h0002, 32'h0000_0000, "ones_status");
        // Phase 2: reset mid-word, then alternating bits
        add_vec(2, 1'b1, 32'h0000, 32'hAAAA_AAAA, "alt_word0");
        add_vec(2, 1'b0, 32'h0001, 32'h0000_0001, "alt_wptr");
        add_vec(2, 1'b0, 32'h0002, 32'h0000_0000, "alt_status");
        // Phase 3: scratch register readback, and a RAM write that must be discarded
        add_vec(3, 1'b1, 32'h1000, 32'h1234_5678, "scratch_rd");
        add_vec(3, 1'b1, 32'h0000, 32'hAAAA_AAAA, "ram_ro");
        // Phase 4: 257 words plus 3 bits of ones
        add_vec(4, 1'b0, 32'h0001, 32'h0000_0001, "wrap_wptr");
        add_vec(4, 1'b0, 32'h0002, 32'h0000_0301, "wrap_status");
        add_vec(4, 1'b1, 32'h0000, 32'hFFFF_FFFF, "wrap_word0");
        // Phase 5: CLEAR
        add_vec(5, 1'b0, 32'h0000, 32'h0000_0001, "clr_ctrl");
        add_vec(5, 1'b0, 32'h0001, 32'h0000_0000, "clr_wptr");
        add_vec(5, 1'b0, 32'h0002, 32'h0000_0000, "clr_status");
        // Phase 6: disabled capture with sync pulses
        add_vec(6, 1'b0, 32'h0000, 32'h0000_0000, "dis_ctrl");
        add_vec(6, 1'b0, 32'h0001, 32'h0000_0000, "dis_wptr");
        add_vec(6, 1'b0, 32'h0002, 32'h0000_0000, "dis_status");
        add_vec(6, 1'b0, 32'h0003, 32'h0000_000A, "dis_synccnt");
        add_vec(6, 1'b0, 32'h0403, 32'h0000_0000, "bank1_synccnt");
        add_vec(6, 1'b0, 32'h0400, 32'h0000_0000, "bank1_ctrl");
        // Phase 7: CLEAR clears SYNCCNT and sets ENABLE
        add_vec(7, 1'b0, 32'h0003, 32'h0000_0000, "clr2_synccnt");
        add_vec(7, 1'b0, 32'h0000, 32'h0000_0001, "clr2_ctrl");

        bus_if.csr_a    = '0;
        bus_if.csr_we   = 1'b0;
        bus_if.csr_di   = '0;
        bus_if.wb_adr_i = '0;
        bus_if.wb_dat_i = '0;
        bus_if.wb_cyc_i = 1'b0;
        bus_if.wb_stb_i = 1'b0;
        bus_if.wb_we_i  = 1'b0;
        bus_if.wb_sel_i = 4'hF;

        repeat (2) @(negedge sys_clk);
        check("rst_csr_do", bus_if.csr_do, 32'd0);
        check("rst_wb_dat", bus_if.wb_dat_o, 32'd0);
        check("rst_wb_ack", {31'd0, bus_if.wb_ack_o}, 32'd0);
        sys_rst = 1'b0;
        run_phase(0);

        for (int i = 0; i < 32; i++) send_bit(1'b1, 1'b0);
        run_phase(1);

        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 32; i++) send_bit(((i % 2) == 0), 1'b0);
        run_phase(2);

        wb_access(1'b1, 32'h1000, 32'h1234_5678, 32'd0, "scratch_wr");
        wb_access(1'b1, 32'h0000, 32'h0000_0000, 32'd0, "ram_wr");
        run_phase(3);

        do_reset();
        for (int i = 0; i < 257 * 32 + 3; i++) send_bit(1'b1, 1'b0);
        run_phase(4);

        csr_write(15'h0000, 32'h3);
        run_phase(5);

        csr_write(15'h0000, 32'h0);
        csr_write(15'h0001, 32'hFF);
        for (int i = 0; i < 64; i++) send_bit(((i % 2) == 0), (i < 10));
        run_phase(6);

        csr_write(15'h0000, 32'h3);
        run_phase(7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gps_receiver2.md
GPS_RECEIVER2 -- requirements
Module: gps_receiver2

Interface
REQ-001 Parameter csr_addr, default 5'h0: CSR bank select, compared against csr_a[14:10].
REQ-002 sys_clk  in  1  sole clock; all logic on rising edge. One clock; reset is asynchronous and active-high.
REQ-003 sys_rst  in  1  asynchronous, active-high reset.
REQ-004 csr_a  in  15  CSR address; csr_a[1:0] selects the register.
REQ-005 csr_we  in  1  CSR write strobe.
REQ-006 csr_di  in  32  CSR write data.
REQ-007 csr_do  out  32  CSR read data, registered.
REQ-008 wb_adr_i  in  32  Wishbone byte address.
REQ-009 wb_dat_i  in  32  Wishbone write data.
REQ-010 wb_dat_o  out  32  Wishbone read data.
REQ-011 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, write enable.
REQ-012 wb_sel_i  in  4  byte selects; ignored, full-word access only.
REQ-013 wb_ack_o  out  1  Wishbone acknowledge.
REQ-014 gps_rec_clk  in  1  front-end bit clock, asynchronous; sampled as data, not used as a clock.
REQ-015 gps_rec_data  in  1  front-end serial sample bit.
REQ-016 gps_rec_sync  in  1  front-end sync/frame marker.

Function
REQ-017 gps_rec_clk, gps_rec_data and gps_rec_sync SHALL each pass through a 2-flop synchronizer on sys_clk.
REQ-018 A bit event SHALL be a 0->1 transition of synchronized gps_rec_clk; data and sync SHALL be taken from the synchronized copies in the same cycle.
REQ-019 On each bit event with ENABLE=1, the data bit SHALL shift into a 32-bit shift register MSB-first (new bit enters bit 0) and a 5-bit bit counter SHALL increment.
REQ-020 When the 32nd bit is shifted in, the completed word SHALL be written to sample RAM (256x32) at WPTR in the same cycle; WPTR SHALL increment modulo 256 and the bit counter SHALL return to 0.
REQ-021 When WPTR wraps 255->0, the sticky WRAP flag SHALL set; only CLEAR or reset clears it.
REQ-022 Each 0->1 transition of synchronized gps_rec_sync SHALL increment the 32-bit SYNCCNT, which wraps at 2^32 and counts regardless of ENABLE.
REQ-023 With ENABLE=0, bit events SHALL be ignored; shift register, bit counter and WPTR SHALL hold.
REQ-024 CSR select: csr_a[14:10]==csr_addr. Registers at csr_a[1:0]: 0 CTRL (bit0 ENABLE, rw; bit1 CLEAR, write-1 pulse, reads 0), 1 WPTR (RO, bits 7:0), 2 STATUS (RO: bit0 WRAP, bits 12:8 bit counter), 3 SYNCCNT (RO).
REQ-025 csr_do SHALL update one cycle after csr_a and SHALL be 0 when the bank is not selected; writes to RO registers SHALL be ignored.
REQ-026 CLEAR SHALL zero WPTR, the bit counter, the shift register, WRAP and SYNCCNT in the cycle after the write, taking priority over a coincident bit event.
REQ-027 Wishbone decode: wb_adr_i[12]=0 selects sample RAM word wb_adr_i[9:2] (read-only; writes acked and discarded); wb_adr_i[12]=1 selects a 32-bit scratch register (read/write), all other bits ignored.
REQ-028 wb_ack_o SHALL assert for exactly one cycle, one cycle after wb_cyc_i&wb_stb_i is seen with wb_ack_o low, and SHALL not reassert in the cycle immediately after an ack.
REQ-029 Read data SHALL be valid on wb_dat_o while wb_ack_o is high; a scratch write SHALL take effect on the acking edge.
REQ-030 A Wishbone RAM read SHALL use a port independent of the capture write port; a same-address collision returns the old word.

Reset
REQ-031 sys_rst SHALL asynchronously clear csr_do, wb_dat_o, wb_ack_o, the synchronizers, shift register, bit counter, WPTR, WRAP, SYNCCNT and scratch to 0, and set ENABLE to 1.
REQ-032 Sample RAM contents are not reset; words not yet written since reset or CLEAR read as undefined.
REQ-033 Reset asserted mid-word SHALL discard the partial word; capture resumes from bit 0 after release.

Verification
REQ-034 gps_rec_data held 1 for 32 bit events after reset -> RAM word 0 (wb addr 0x0) = 0xFFFFFFFF, CSR WPTR=1, STATUS bits 12:8 = 0.
REQ-035 Alternating data 1,0,1,0... for 32 bits -> word 0 = 0xAAAAAAAA; wb read 0x0 acked one cycle after strobe.
REQ-036 wb write 0x1000 = 0x12345678, then wb read 0x1000 -> 0x12345678; each ack is a single-cycle pulse.
REQ-037 256x32 bit events -> WPTR=0, STATUS bit0=1; CSR write CTRL=0x3 -> WPTR=0, WRAP=0, ENABLE=1.
REQ-038 CTRL=0, then 64 bit events with 10 sync pulses -> WPTR unchanged, SYNCCNT=10; csr_a[14:10]=1 -> csr_do=0.
